// File: rtl/uart_frame_pkg.sv
// Shared types and defaults for the UART frame loader.
// State and error encodings are visible to the top-level sequencer.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_PAYLOAD = 2'd2,
    S_CHECK   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_ABORT   = 2'd3
  } err_t;

  localparam logic [7:0] SYNC0_DEFAULT = 8'hA5;
  localparam logic [7:0] SYNC1_DEFAULT = 8'h5A;

  // Width of a byte-within-pixel index; a 1-byte pixel still needs one bit.
  function automatic int idx_width(input int pixel_bytes);
    return (pixel_bytes > 1) ? $clog2(pixel_bytes) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_loader_packer.sv
// Packs consecutive bytes into one pixel word, first byte in the low lane.
// word_valid pulses on the clock after the byte that completes the pixel.
module byte_pixel_packer
  import uart_frame_pkg::*;
#(
  parameter int PIXEL_BYTES = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     byte_valid,
  input  logic [7:0]               data_byte,
  output logic                     word_valid,
  output logic [8*PIXEL_BYTES-1:0] word
);

  localparam int               IDX_W    = idx_width(PIXEL_BYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXEL_BYTES - 1);

  logic [IDX_W-1:0]         idx;
  logic [8*PIXEL_BYTES-1:0] acc;
  logic [8*PIXEL_BYTES-1:0] acc_merged;

  always_comb begin
    acc_merged = acc;
    acc_merged[8*idx +: 8] = data_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      acc        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= '0;
        acc <= '0;
      end else if (byte_valid) begin
        if (idx == IDX_LAST) begin
          word       <= acc_merged;
          word_valid <= 1'b1;
          acc        <= '0;
          idx        <= '0;
        end else begin
          acc <= acc_merged;
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_frame_loader.sv
// Loads a framed UART byte stream (sync, pixels, XOR checksum) into a frame buffer.
//
//   state     | meaning
//   S_IDLE    | hunting for SYNC0, no timeout
//   S_SYNC    | SYNC0 seen, expecting SYNC1
//   S_PAYLOAD | packing pixel bytes, writing one word per pixel
//   S_CHECK   | all pixels written, next byte is the checksum
module uart_frame_loader
  import uart_frame_pkg::*;
#(
  parameter int         IMG_WIDTH      = 1280,
  parameter int         IMG_HEIGHT     = 720,
  parameter int         PIXEL_BYTES    = 3,
  parameter int         ADDR_WIDTH     = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter logic [7:0] SYNC0          = SYNC0_DEFAULT,
  parameter logic [7:0] SYNC1          = SYNC1_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 2500000
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_rx_dv,
  input  logic [7:0]               i_rx_byte,
  input  logic                     i_abort,
  output logic                     o_fb_wr_en,
  output logic [ADDR_WIDTH-1:0]    o_fb_wr_addr,
  output logic [8*PIXEL_BYTES-1:0] o_fb_wr_data,
  output logic                     o_busy,
  output logic                     o_frame_done,
  output logic                     o_frame_err,
  output logic [1:0]               o_err_code,
  output logic [ADDR_WIDTH:0]      o_pixel_cnt
);

  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int IDX_W = idx_width(PIXEL_BYTES);

  localparam logic [CNT_W-1:0] PIX_LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] PIX_FULL = CNT_W'(TOTAL);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXEL_BYTES - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES);

  state_t                state;
  state_t                state_nxt;
  err_t                  err_code;
  err_t                  err_nxt;
  logic [CNT_W-1:0]      pix_cnt;
  logic [IDX_W-1:0]      byte_idx;
  logic [7:0]            csum;
  logic [TO_W-1:0]       idle_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  done_q;
  logic                  err_q;

  logic abort_hit;
  logic timeout_hit;
  logic sync_ok;
  logic pack_valid;
  logic done_set;
  logic err_set;
  logic pixel_last_byte;

  assign abort_hit       = i_abort && (state != S_IDLE);
  // Terminal count: the last idle clock of the window, and no byte arriving to rescue it.
  assign timeout_hit     = (state != S_IDLE) && !i_rx_dv && (idle_cnt == TO_W'(1));
  assign pixel_last_byte = (byte_idx == IDX_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    err_nxt    = ERR_NONE;
    sync_ok    = 1'b0;
    pack_valid = 1'b0;
    done_set   = 1'b0;
    err_set    = 1'b0;
    if (abort_hit) begin
      state_nxt = S_IDLE;
      err_set   = 1'b1;
      err_nxt   = ERR_ABORT;
    end else if (i_rx_dv) begin
      unique case (state)
        S_IDLE: begin
          if (i_rx_byte == SYNC0) state_nxt = S_SYNC;
        end
        S_SYNC: begin
          if (i_rx_byte == SYNC1) begin
            state_nxt = S_PAYLOAD;
            sync_ok   = 1'b1;
          end else if (i_rx_byte != SYNC0) begin
            state_nxt = S_IDLE;
          end
        end
        S_PAYLOAD: begin
          pack_valid = 1'b1;
          if (pixel_last_byte && (pix_cnt == PIX_LAST)) state_nxt = S_CHECK;
        end
        S_CHECK: begin
          state_nxt = S_IDLE;
          if (i_rx_byte == csum) begin
            done_set = 1'b1;
          end else begin
            err_set = 1'b1;
            err_nxt = ERR_CSUM;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt = S_IDLE;
      err_set   = 1'b1;
      err_nxt   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      done_q <= done_set;
      err_q  <= err_set;
      if (sync_ok) begin
        err_code <= ERR_NONE;
      end else if (err_set) begin
        err_code <= err_nxt;
      end
    end
  end

  // Pixel count and address advance on the completing byte so the write
  // strobe one clock later already carries its address.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_cnt  <= '0;
      byte_idx <= '0;
      csum     <= '0;
      wr_addr  <= '0;
    end else if (sync_ok) begin
      pix_cnt  <= '0;
      byte_idx <= '0;
      csum     <= '0;
    end else if (pack_valid) begin
      csum <= csum ^ i_rx_byte;
      if (pixel_last_byte) begin
        byte_idx <= '0;
        wr_addr  <= pix_cnt[ADDR_WIDTH-1:0];
        if (pix_cnt != PIX_FULL) pix_cnt <= pix_cnt + 1'b1;
      end else begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_cnt <= '0;
    end else if (i_rx_dv) begin
      idle_cnt <= TO_LOAD;
    end else if ((state != S_IDLE) && (idle_cnt != '0)) begin
      idle_cnt <= idle_cnt - 1'b1;
    end
  end

  byte_pixel_packer #(
    .PIXEL_BYTES(PIXEL_BYTES)
  ) u_packer (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (sync_ok),
    .byte_valid(pack_valid),
    .data_byte (i_rx_byte),
    .word_valid(o_fb_wr_en),
    .word      (o_fb_wr_data)
  );

  assign o_fb_wr_addr = wr_addr;
  assign o_busy       = (state != S_IDLE);
  assign o_frame_done = done_q;
  assign o_frame_err  = err_q;
  assign o_err_code   = err_code;
  assign o_pixel_cnt  = pix_cnt;

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench: protocol-level model with per-cycle compare, plus a 1-byte-pixel build.
module tb_uart_frame_loader;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int PB    = 3;
  localparam int TO    = 100;
  localparam int TOTAL = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        abort = 1'b0;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [23:0] wr_data;
  logic        busy, done, ferr;
  logic [1:0]  err_code;
  logic [3:0]  pix;

  logic        rx2_dv = 1'b0;
  logic [7:0]  rx2_byte = 8'h00;
  logic        abort2 = 1'b0;
  logic        wr2_en;
  logic [2:0]  wr2_addr;
  logic [7:0]  wr2_data;
  logic        busy2, done2, ferr2;
  logic [1:0]  err2;
  logic [3:0]  pix2;

  uart_frame_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BYTES(PB), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_dv(rx_dv), .i_rx_byte(rx_byte), .i_abort(abort),
    .o_fb_wr_en(wr_en), .o_fb_wr_addr(wr_addr), .o_fb_wr_data(wr_data), .o_busy(busy),
    .o_frame_done(done), .o_frame_err(ferr), .o_err_code(err_code), .o_pixel_cnt(pix));

  uart_frame_loader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIXEL_BYTES(1), .TIMEOUT_CYCLES(TO)) dut_pb1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_rx_dv(rx2_dv), .i_rx_byte(rx2_byte), .i_abort(abort2),
    .o_fb_wr_en(wr2_en), .o_fb_wr_addr(wr2_addr), .o_fb_wr_data(wr2_data), .o_busy(busy2),
    .o_frame_done(done2), .o_frame_err(ferr2), .o_err_code(err2), .o_pixel_cnt(pix2));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Protocol model: what a receiver of this framing must do, byte by byte.
  typedef struct {
    int          cyc;
    logic [2:0]  addr;
    logic [23:0] data;
  } wr_t;

  wr_t         q_wr[$];
  int          q_done[$];
  int          q_err[$];
  int          m_phase = 0;    // 0 hunting, 1 after SYNC0, 2 in pixels, 3 awaiting checksum
  int          m_k = 0;
  int          m_pix = 0;
  int          m_idle = 0;
  logic [7:0]  m_csum = 8'h00;
  logic [23:0] m_word = 24'h0;
  logic [1:0]  m_err = 2'd0;

  task automatic model_step(input logic dv, input logic [7:0] b, input logic ab);
    wr_t w;
    if (ab && m_phase != 0) begin
      q_err.push_back(cyc + 1);
      m_err   = 2'd3;
      m_phase = 0;
    end else if (dv) begin
      m_idle = 0;
      case (m_phase)
        0: if (b == 8'hA5) m_phase = 1;
        1: begin
          if (b == 8'h5A) begin
            m_phase = 2; m_k = 0; m_pix = 0; m_csum = 8'h00; m_word = 24'h0; m_err = 2'd0;
          end else if (b != 8'hA5) begin
            m_phase = 0;
          end
        end
        2: begin
          m_csum = m_csum ^ b;
          m_word[8*m_k +: 8] = b;
          m_k++;
          if (m_k == PB) begin
            w.cyc = cyc + 1; w.addr = m_pix[2:0]; w.data = m_word;
            q_wr.push_back(w);
            m_pix++; m_k = 0; m_word = 24'h0;
            if (m_pix == TOTAL) m_phase = 3;
          end
        end
        default: begin
          if (b == m_csum) q_done.push_back(cyc + 1);
          else begin q_err.push_back(cyc + 1); m_err = 2'd1; end
          m_phase = 0;
        end
      endcase
    end else if (m_phase != 0) begin
      m_idle++;
      if (m_idle == TO) begin
        q_err.push_back(cyc + 1);
        m_err   = 2'd2;
        m_phase = 0;
      end
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_k = 0; m_pix = 0; m_idle = 0; m_csum = 8'h00; m_word = 24'h0; m_err = 2'd0;
    q_wr.delete(); q_done.delete(); q_err.delete();
  endtask

  logic       e_busy = 1'b0;
  logic [1:0] e_err = 2'd0;
  logic [3:0] e_pix = 4'd0;
  always @(posedge clk) begin
    e_busy <= (m_phase != 0);
    e_err  <= m_err;
    e_pix  <= m_pix[3:0];
  end

  int          n_wr = 0, n_done = 0, n_err = 0;
  logic [23:0] log_data[8];

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_w, exp_d, exp_e;
      wr_t  w;
      check("busy", busy, e_busy);
      check("err_code", err_code, e_err);
      check("pixel_cnt", pix, e_pix);
      exp_w = (q_wr.size() > 0) && (q_wr[0].cyc == cyc);
      check("wr_en", wr_en, exp_w);
      if (exp_w) begin
        w = q_wr.pop_front();
        check("wr_addr", wr_addr, w.addr);
        check("wr_data", wr_data, w.data);
      end
      exp_d = (q_done.size() > 0) && (q_done[0] == cyc);
      check("frame_done", done, exp_d);
      if (exp_d) void'(q_done.pop_front());
      exp_e = (q_err.size() > 0) && (q_err[0] == cyc);
      check("frame_err", ferr, exp_e);
      if (exp_e) void'(q_err.pop_front());
      if (wr_en) begin n_wr++; log_data[wr_addr] = wr_data; end
      if (done) n_done++;
      if (ferr) n_err++;
    end
  end

  logic [7:0] d2[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  int n2 = 0, n2_done = 0, n2_err = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr2_en) begin
        if (n2 < 8) begin
          check("pb1_addr", wr2_addr, n2[2:0]);
          check("pb1_data", wr2_data, d2[n2]);
        end else begin
          check("pb1_write_count", n2 + 1, 8);
        end
        n2++;
      end
      if (done2) n2_done++;
      if (ferr2) n2_err++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input logic dv, input logic [7:0] b, input logic ab);
    rx_dv = dv; rx_byte = b; abort = ab;
    model_step(dv, b, ab);
    tick();
    rx_dv = 1'b0; abort = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    cycle(1'b1, b, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  // kind 0: bytes 01..18; kind 1: alternating sync values as data.
  task automatic send_frame(input int kind, input bit bad, output logic [7:0] cs);
    logic [7:0] b;
    cs = 8'h00;
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < TOTAL * PB; i++) begin
      b = (kind == 0) ? 8'(i + 1) : ((i % 2 == 0) ? 8'hA5 : 8'h5A);
      cs = cs ^ b;
      send_byte(b);
    end
    send_byte(bad ? 8'hFF : cs);
  endtask

  task automatic cycle2(input logic dv, input logic [7:0] b);
    rx2_dv = dv; rx2_byte = b;
    model_step(1'b0, 8'h00, 1'b0);
    tick();
    rx2_dv = 1'b0;
  endtask

  initial begin
    logic [7:0] cs;
    int s_wr, s_done, s_err;

    #2 rst_n = 1'b0;
    #1;
    check("reset_outputs", {wr_en, wr_addr, wr_data, busy, done, ferr, err_code, pix}, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // 1: good frame
    s_wr = n_wr; s_done = n_done; s_err = n_err;
    send_frame(0, 1'b0, cs);
    idle(2);
    check("t1_csum", cs, 8'h18);
    check("t1_writes", n_wr - s_wr, 8);
    check("t1_done", n_done - s_done, 1);
    check("t1_err", n_err - s_err, 0);
    check("t1_err_code", err_code, 2'd0);
    check("t1_addr0_data", log_data[0], 24'h030201);
    check("t1_addr7_data", log_data[7], 24'h181716);

    // 2: bad checksum
    s_wr = n_wr; s_done = n_done; s_err = n_err;
    send_frame(0, 1'b1, cs);
    idle(2);
    check("t2_writes", n_wr - s_wr, 8);
    check("t2_done", n_done - s_done, 0);
    check("t2_err", n_err - s_err, 1);
    check("t2_err_code", err_code, 2'd1);

    // 3: timeout after 10 payload bytes, then recovery
    s_wr = n_wr; s_err = n_err;
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h40 + i));
    idle(TO + 5);
    check("t3_err", n_err - s_err, 1);
    check("t3_err_code", err_code, 2'd2);
    check("t3_pixel_cnt", pix, 4'd3);
    check("t3_busy", busy, 1'b0);
    check("t3_writes", n_wr - s_wr, 3);
    s_done = n_done;
    send_frame(0, 1'b0, cs);
    idle(2);
    check("t3_recover_done", n_done - s_done, 1);
    check("t3_recover_err_code", err_code, 2'd0);

    // 4: sync hunting, sync values inside payload, false start
    s_done = n_done;
    send_byte(8'h00);
    send_byte(8'hA5);
    send_frame(1, 1'b0, cs);
    idle(2);
    check("t4_done", n_done - s_done, 1);
    check("t4_pixel_cnt", pix, 4'd8);
    s_wr = n_wr; s_err = n_err;
    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'h11);
    idle(3);
    check("t4_false_writes", n_wr - s_wr, 0);
    check("t4_false_err", n_err - s_err, 0);
    check("t4_false_busy", busy, 1'b0);

    // 5: abort on the 6th payload byte, then abort while idle
    s_wr = n_wr; s_err = n_err;
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i));
    cycle(1'b1, 8'h65, 1'b1);
    check("t5_busy_next", busy, 1'b0);
    idle(2);
    check("t5_err_code", err_code, 2'd3);
    check("t5_writes", n_wr - s_wr, 1);
    check("t5_pixel_cnt", pix, 4'd1);
    check("t5_err", n_err - s_err, 1);
    s_err = n_err;
    cycle(1'b0, 8'h00, 1'b1);
    idle(2);
    check("t5_idle_abort", n_err - s_err, 0);

    // 6a: 1-byte pixels
    cycle2(1'b1, 8'hA5); cycle2(1'b0, 8'h00);
    cycle2(1'b1, 8'h5A); cycle2(1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      cycle2(1'b1, d2[i]);
      cycle2(1'b0, 8'h00);
    end
    cycle2(1'b1, 8'h88);
    for (int i = 0; i < 3; i++) cycle2(1'b0, 8'h00);
    check("pb1_writes", n2, 8);
    check("pb1_done", n2_done, 1);
    check("pb1_err", n2_err, 0);

    // 6b: reset in the middle of a payload
    s_done = n_done; s_err = n_err;
    send_byte(8'hA5);
    send_byte(8'h5A);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h70 + i));
    check("t6_busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_reset_outputs", {wr_en, wr_addr, wr_data, busy, done, ferr, err_code, pix}, 32'h0);
    idle(3);
    check("t6_no_pulse_done", n_done - s_done, 0);
    check("t6_no_pulse_err", n_err - s_err, 0);
    rst_n = 1'b1;
    idle(2);
    send_frame(0, 1'b0, cs);
    idle(2);
    check("t6_after_reset_done", n_done - s_done, 1);

    check("pending_writes", q_wr.size(), 0);
    check("pending_done", q_done.size(), 0);
    check("pending_err", q_err.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
